hazard5_regfile_ctrl: RTL and testbench
=======================================

Name: hazard5_regfile_ctrl

Overview:
- Sequencer and port-sharing controller in front of the 1-write/2-read register file.
- After reset it zero-initialises every register, because the inferred regfile has no reset.
- It then passes core write and read-port-1 traffic through to the regfile.
- While the core is halted it services debug-module register reads and writes with a req/ack handshake, and enforces x0 write suppression.

Parameters:
- N_REGS, 16, number of architectural registers; must satisfy N_REGS <= 2**W_ADDR.
- W_DATA, 32, register width in bits.
- W_ADDR, 5, register address width.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous reset, active-high
- core_halted  in  1  core is halted and not using the regfile
- core_stall  out  1  holds the core off the regfile (init in progress)
- init_done  out  1  high once the zero-init pass is complete
- clr_req  in  1  pulse: re-run zero-init; honoured only in RUN with core_halted=1
- core_raddr1  in  W_ADDR  core read port 1 address
- core_wen  in  1  core writeback enable
- core_waddr  in  W_ADDR  core writeback address
- core_wdata  in  W_DATA  core writeback data
- dbg_req  in  1  debug access request; held until dbg_ack
- dbg_write  in  1  1 = write, 0 = read; stable while dbg_req=1
- dbg_addr  in  W_ADDR  debug register address
- dbg_wdata  in  W_DATA  debug write data
- dbg_ack  out  1  one-cycle completion pulse
- dbg_rdata  out  W_DATA  read result; valid in the ack cycle, held until the next read completes
- rf_raddr1  out  W_ADDR  to regfile raddr1
- rf_rdata1  in  W_DATA  from regfile rdata1 (registered there; valid 1 cycle after address)
- rf_wen  out  1  to regfile wen
- rf_waddr  out  W_ADDR  to regfile waddr
- rf_wdata  out  W_DATA  to regfile wdata
- Regfile raddr2/rdata2 and rdata1-to-core are wired directly and do not pass through this block.

Behaviour:
- Reset values: state=INIT, init counter=0, core_stall=1, init_done=0, dbg_ack=0, dbg_rdata=0.
- rf_* outputs are combinational from state and inputs. During reset they write 0 to address 0, which is harmless.

States:
- INIT
  - rf_wen=1, rf_waddr=counter, rf_wdata=0. Counter increments each cycle.
  - On counter==N_REGS-1: go to RUN, set init_done=1, clear core_stall at the same edge.
  - Addresses 0..N_REGS-1 are written exactly once each: N_REGS cycles total after rst falls.
  - core_stall=1 throughout. dbg_req and core_wen are ignored.
- RUN
  - rf_raddr1=core_raddr1.
  - If core_halted=0: rf_wen=core_wen && core_waddr!=0, rf_waddr=core_waddr, rf_wdata=core_wdata.
  - If core_halted=1: core_wen is ignored (rf_wen=0) unless a debug write is issued.
  - Priority when core_halted=1, highest first: clr_req (counter:=0, init_done:=0, core_stall:=1, go to INIT); then dbg_req.
  - dbg_req with core_halted=0 is held pending; no ack until the core halts.
  - Debug write accept (cycle T): rf_wen=(dbg_addr!=0), rf_waddr=dbg_addr, rf_wdata=dbg_wdata. Go to ACK; dbg_ack=1 in T+1.
  - Debug read accept (T): rf_raddr1=dbg_addr; go to RDCAP.
- RDCAP (T+1)
  - Capture rf_rdata1 into dbg_rdata at the end of the cycle; go to ACK. dbg_ack=1 in T+2.
- ACK
  - dbg_ack=1 for exactly one cycle; rf_wen=0; rf_raddr1=core_raddr1. Return to RUN.
  - dbg_req is ignored in the ACK cycle; the requester drops or changes it here.
  - Back-to-back accesses: a new accept is possible the cycle after ACK.

Other rules:
- Address 0 is never written except by INIT, so reads of x0 return 0.
- Debug addresses >= N_REGS: the write is dropped, the read returns 0; still acked with the same latency.
- core_halted falling mid-access: the access completes and acks normally.
- clr_req outside RUN, or with core_halted=0, is ignored and not remembered.
- rst asserted mid-operation: return to INIT immediately; any pending ack is lost and the requester must re-request.

Test Plan:
- Reset release, N_REGS=16 -> rf_wen=1 with waddr 0..15, wdata=0 for 16 consecutive cycles; core_stall falls and init_done rises after the 16th write; then a debug read of x5 returns 0.
- Halted, debug write x3=0xDEADBEEF, then debug read x3 -> write ack 1 cycle after accept; read ack 2 cycles after accept with dbg_rdata=0xDEADBEEF; ack pulses exactly 1 cycle.
- Debug write x0=0x12345678 and core_wen to x0 (not halted) -> rf_wen stays 0; a later debug read of x0 returns 0.
- dbg_req held with core_halted=0 while the core writes x7=0x55 -> no ack, core write reaches the regfile; raise core_halted -> request serviced, read x7 returns 0x55.
- Halted, clr_req pulse after x3 holds 0xDEADBEEF -> 16-cycle zero-init reruns with core_stall=1; x3 then reads 0. clr_req with core_halted=0 -> no effect.
- Assert rst in the RDCAP cycle -> dbg_ack never pulses, dbg_rdata=0; init restarts at address 0.

Source files
------------

// File: rtl/hazard5_regfile_ctrl.sv
// Regfile sequencer: zero-initialises the reset-less register file, then shares its
// write port and read port 1 between the core and a req/ack debug access path.
module hazard5_regfile_ctrl #(
    parameter int unsigned N_REGS = 16,
    parameter int unsigned W_DATA = 32,
    parameter int unsigned W_ADDR = 5
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              core_halted,
    output logic              core_stall,
    output logic              init_done,
    input  logic              clr_req,

    input  logic [W_ADDR-1:0] core_raddr1,
    input  logic              core_wen,
    input  logic [W_ADDR-1:0] core_waddr,
    input  logic [W_DATA-1:0] core_wdata,

    input  logic              dbg_req,
    input  logic              dbg_write,
    input  logic [W_ADDR-1:0] dbg_addr,
    input  logic [W_DATA-1:0] dbg_wdata,
    output logic              dbg_ack,
    output logic [W_DATA-1:0] dbg_rdata,

    output logic [W_ADDR-1:0] rf_raddr1,
    input  logic [W_DATA-1:0] rf_rdata1,
    output logic              rf_wen,
    output logic [W_ADDR-1:0] rf_waddr,
    output logic [W_DATA-1:0] rf_wdata
);

    typedef enum logic [1:0] {
        INIT,
        RUN,
        RDCAP,
        ACK
    } state_t;

    localparam logic [W_ADDR-1:0] LAST_REG  = W_ADDR'(N_REGS - 1);
    localparam logic [W_ADDR:0]   REG_LIMIT = (W_ADDR + 1)'(N_REGS);

    state_t            state;
    logic [W_ADDR-1:0] counter;
    logic              rd_oob;

    logic dbg_in_range;
    logic dbg_accept;

    assign dbg_in_range = ({1'b0, dbg_addr} < REG_LIMIT);
    // clr_req outranks a debug request in the same halted cycle
    assign dbg_accept   = (state == RUN) && core_halted && !clr_req && dbg_req;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= INIT;
            counter    <= '0;
            core_stall <= 1'b1;
            init_done  <= 1'b0;
            dbg_ack    <= 1'b0;
            dbg_rdata  <= '0;
            rd_oob     <= 1'b0;
        end else begin
            dbg_ack <= 1'b0;
            unique case (state)
                INIT: begin
                    counter <= counter + 1'b1;
                    if (counter == LAST_REG) begin
                        state      <= RUN;
                        init_done  <= 1'b1;
                        core_stall <= 1'b0;
                    end
                end
                RUN: begin
                    if (core_halted && clr_req) begin
                        state      <= INIT;
                        counter    <= '0;
                        init_done  <= 1'b0;
                        core_stall <= 1'b1;
                    end else if (dbg_accept) begin
                        rd_oob <= !dbg_in_range;
                        if (dbg_write) begin
                            state   <= ACK;
                            dbg_ack <= 1'b1;
                        end else begin
                            state <= RDCAP;
                        end
                    end
                end
                RDCAP: begin
                    dbg_rdata <= rd_oob ? '0 : rf_rdata1;
                    state     <= ACK;
                    dbg_ack   <= 1'b1;
                end
                ACK: begin
                    state <= RUN;
                end
                default: state <= INIT;
            endcase
        end
    end

    always_comb begin
        rf_raddr1 = core_raddr1;
        rf_wen    = 1'b0;
        rf_waddr  = core_waddr;
        rf_wdata  = core_wdata;
        unique case (state)
            INIT: begin
                rf_wen   = 1'b1;
                rf_waddr = counter;
                rf_wdata = '0;
            end
            RUN: begin
                if (!core_halted) begin
                    rf_wen = core_wen && (core_waddr != '0);
                end else if (dbg_accept) begin
                    if (dbg_write) begin
                        rf_wen   = dbg_in_range && (dbg_addr != '0);
                        rf_waddr = dbg_addr;
                        rf_wdata = dbg_wdata;
                    end else begin
                        rf_raddr1 = dbg_addr;
                    end
                end
            end
            RDCAP: begin
                rf_raddr1 = dbg_addr;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_hazard5_regfile_ctrl.sv
// Scoreboard bench for hazard5_regfile_ctrl: stimulus pushes expected regfile writes
// and debug acks into queues; a negedge monitor pops and compares them.
module tb_hazard5_regfile_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        core_halted;
    logic        core_stall;
    logic        init_done;
    logic        clr_req;
    logic [4:0]  core_raddr1;
    logic        core_wen;
    logic [4:0]  core_waddr;
    logic [31:0] core_wdata;
    logic        dbg_req;
    logic        dbg_write;
    logic [4:0]  dbg_addr;
    logic [31:0] dbg_wdata;
    logic        dbg_ack;
    logic [31:0] dbg_rdata;
    logic [4:0]  rf_raddr1;
    logic [31:0] rf_rdata1;
    logic        rf_wen;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;

    hazard5_regfile_ctrl #(
        .N_REGS(16),
        .W_DATA(32),
        .W_ADDR(5)
    ) dut (
        .clk(clk),
        .rst(rst),
        .core_halted(core_halted),
        .core_stall(core_stall),
        .init_done(init_done),
        .clr_req(clr_req),
        .core_raddr1(core_raddr1),
        .core_wen(core_wen),
        .core_waddr(core_waddr),
        .core_wdata(core_wdata),
        .dbg_req(dbg_req),
        .dbg_write(dbg_write),
        .dbg_addr(dbg_addr),
        .dbg_wdata(dbg_wdata),
        .dbg_ack(dbg_ack),
        .dbg_rdata(dbg_rdata),
        .rf_raddr1(rf_raddr1),
        .rf_rdata1(rf_rdata1),
        .rf_wen(rf_wen),
        .rf_waddr(rf_waddr),
        .rf_wdata(rf_wdata)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Reset-less regfile with a registered read port, preloaded with junk
    logic [31:0] mem [32];
    logic        preload;
    always @(posedge clk) begin
        if (preload) begin
            for (int i = 0; i < 32; i++) mem[i] <= 32'hA5A5_0000 | 32'(i);
        end else if (rf_wen) begin
            mem[rf_waddr] <= rf_wdata;
        end
        rf_rdata1 <= mem[rf_raddr1];
    end

    typedef struct { int cyc; logic [31:0] data; } ack_t;
    typedef struct { logic [4:0] addr; logic [31:0] data; } wr_t;
    ack_t ack_q[$];
    wr_t  wr_q[$];

    int n_pass  = 0;
    int n_total = 0;
    logic [31:0] last_rd = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    endtask

    task automatic flag(input string name);
        n_total++;
        $display("FAIL %s: got unexpected event, expected none (cycle %0d)", name, cyc);
    endtask

    // Monitor: every regfile write and every debug ack must match a queued expectation
    wr_t  mon_w;
    ack_t mon_a;
    bit   ack_prev = 1'b0;
    always @(negedge clk) begin
        if (!rst) begin
            if (rf_wen) begin
                if (wr_q.size() == 0) flag("unexpected_rf_write");
                else begin
                    mon_w = wr_q.pop_front();
                    check("rf_waddr", 32'(rf_waddr), 32'(mon_w.addr));
                    check("rf_wdata", rf_wdata, mon_w.data);
                end
            end
            if (ack_prev) check("ack_width", 32'(dbg_ack), 32'd0);
            if (dbg_ack) begin
                if (ack_q.size() == 0) flag("unexpected_ack");
                else begin
                    mon_a = ack_q.pop_front();
                    check("ack_cycle", 32'(cyc), 32'(mon_a.cyc));
                    check("dbg_rdata", dbg_rdata, mon_a.data);
                end
            end
        end
        ack_prev = dbg_ack && !rst;
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push_init();
        for (int i = 0; i < 16; i++) wr_q.push_back('{addr: 5'(i), data: 32'd0});
    endtask

    task automatic expect_ack(input int acc_cyc, input bit is_read, input logic [31:0] rd);
        ack_t a;
        a.cyc  = acc_cyc + (is_read ? 2 : 1);
        a.data = is_read ? rd : last_rd;
        if (is_read) last_rd = rd;
        ack_q.push_back(a);
    endtask

    task automatic dbg_start(input bit wr, input logic [4:0] a, input logic [31:0] d);
        tick(1);
        dbg_req   = 1'b1;
        dbg_write = wr;
        dbg_addr  = a;
        dbg_wdata = d;
    endtask

    // Waits for the ack (bounded) and drops the request inside the ack cycle
    task automatic dbg_wait();
        bit got = 1'b0;
        for (int i = 0; i < 30 && !got; i++) begin
            @(negedge clk);
            if (dbg_ack) got = 1'b1;
        end
        dbg_req = 1'b0;
        n_total++;
        if (got) n_pass++;
        else $display("FAIL ack_timeout: got no ack, expected ack within 30 cycles (cycle %0d)", cyc);
    endtask

    task automatic dbg_access(input bit wr, input logic [4:0] a, input logic [31:0] d,
                              input logic [31:0] exp_rd);
        dbg_start(wr, a, d);
        if (wr && a != 5'd0 && a < 5'd16) wr_q.push_back('{addr: a, data: d});
        expect_ack(cyc, !wr, exp_rd);
        dbg_wait();
    endtask

    initial begin
        rst = 1'b1; preload = 1'b1; core_halted = 1'b1; clr_req = 1'b0;
        core_raddr1 = 5'd1; core_wen = 1'b0; core_waddr = '0; core_wdata = '0;
        dbg_req = 1'b0; dbg_write = 1'b0; dbg_addr = '0; dbg_wdata = '0;
        tick(1);
        preload = 1'b0;
        @(negedge clk);
        check("rst_core_stall", 32'(core_stall), 32'd1);
        check("rst_init_done", 32'(init_done), 32'd0);
        check("rst_dbg_ack", 32'(dbg_ack), 32'd0);
        check("rst_dbg_rdata", dbg_rdata, 32'd0);
        check("rst_rf_wen", 32'(rf_wen), 32'd1);
        check("rst_rf_waddr", 32'(rf_waddr), 32'd0);

        // Zero-init after reset release: 16 writes, then RUN
        push_init();
        tick(1);
        rst = 1'b0;
        repeat (16) @(negedge clk);
        check("init_stall_15", 32'(core_stall), 32'd1);
        check("init_done_15", 32'(init_done), 32'd0);
        @(negedge clk);
        check("init_stall_16", 32'(core_stall), 32'd0);
        check("init_done_16", 32'(init_done), 32'd1);
        check("init_wr_q_drained", 32'(wr_q.size()), 32'd0);

        dbg_access(1'b0, 5'd5, '0, 32'd0);
        dbg_access(1'b1, 5'd3, 32'hDEADBEEF, '0);
        dbg_access(1'b0, 5'd3, '0, 32'hDEADBEEF);

        // x0 suppression from debug and core; core writes ignored while halted
        dbg_access(1'b1, 5'd0, 32'h12345678, '0);
        tick(1);
        core_halted = 1'b0; core_wen = 1'b1; core_waddr = 5'd0; core_wdata = 32'h77;
        tick(1);
        core_halted = 1'b1; core_waddr = 5'd4;
        tick(1);
        core_wen = 1'b0;
        dbg_access(1'b0, 5'd0, '0, 32'd0);
        dbg_access(1'b0, 5'd4, '0, 32'd0);

        // Pending request while running; core write x7 goes through
        core_halted = 1'b0;
        dbg_start(1'b0, 5'd7, '0);
        core_wen = 1'b1; core_waddr = 5'd7; core_wdata = 32'h55;
        wr_q.push_back('{addr: 5'd7, data: 32'h55});
        tick(1);
        core_wen = 1'b0;
        tick(3);
        @(negedge clk);
        check("pending_no_ack", 32'(dbg_ack), 32'd0);
        tick(1);
        core_halted = 1'b1;
        expect_ack(cyc, 1'b1, 32'h55);
        dbg_wait();

        // clr_req while running is ignored
        tick(1);
        core_halted = 1'b0; clr_req = 1'b1;
        tick(1);
        clr_req = 1'b0;
        @(negedge clk);
        check("clr_ignored_stall", 32'(core_stall), 32'd0);
        check("clr_ignored_done", 32'(init_done), 32'd1);
        core_halted = 1'b1;
        dbg_access(1'b0, 5'd3, '0, 32'hDEADBEEF);

        // clr_req while halted reruns the zero-init
        tick(1);
        clr_req = 1'b1;
        push_init();
        tick(1);
        clr_req = 1'b0;
        @(negedge clk);
        check("clr_stall", 32'(core_stall), 32'd1);
        check("clr_done", 32'(init_done), 32'd0);
        repeat (15) @(negedge clk);
        check("clr_done_15", 32'(init_done), 32'd0);
        @(negedge clk);
        check("clr_done_16", 32'(init_done), 32'd1);
        dbg_access(1'b0, 5'd3, '0, 32'd0);

        // Out-of-range addresses, back-to-back accesses
        dbg_access(1'b1, 5'd20, 32'h11111111, '0);
        dbg_access(1'b0, 5'd20, '0, 32'd0);
        dbg_access(1'b1, 5'd9, 32'hCAFEF00D, '0);
        dbg_access(1'b0, 5'd9, '0, 32'hCAFEF00D);

        // core_halted falls mid-read; access still completes
        dbg_access(1'b1, 5'd9, 32'h0BADF00D, '0);
        dbg_start(1'b0, 5'd9, '0);
        expect_ack(cyc, 1'b1, 32'h0BADF00D);
        tick(1);
        core_halted = 1'b0;
        dbg_wait();
        tick(1);
        core_halted = 1'b1;

        // Reset during RDCAP: ack lost, rdata cleared, init restarts at 0
        dbg_start(1'b0, 5'd9, '0);
        tick(1);
        rst = 1'b1;
        dbg_req = 1'b0;
        last_rd = '0;
        @(negedge clk);
        check("rdcap_rst_ack", 32'(dbg_ack), 32'd0);
        check("rdcap_rst_rdata", dbg_rdata, 32'd0);
        check("rdcap_rst_stall", 32'(core_stall), 32'd1);
        push_init();
        tick(1);
        rst = 1'b0;
        repeat (17) @(negedge clk);
        check("rerst_done", 32'(init_done), 32'd1);
        dbg_access(1'b0, 5'd9, '0, 32'd0);

        tick(2);
        check("wr_q_empty", 32'(wr_q.size()), 32'd0);
        check("ack_q_empty", 32'(ack_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish, expected finish before 200000");
        $fatal(1);
    end

endmodule
